// File: rtl/priority_arbiter.sv
// 4-requester arbiter with registered one-hot grant, bounded hold time and a one-cycle turnaround gap.
// Define ROUND_ROBIN_EN for rotating priority; the default build uses fixed priority 3 > 2 > 1 > 0.
module priority_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t           state, state_nxt;
  logic [3:0]       gnt_nxt;
  logic [1:0]       gnt_id_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic [3:0]       mask, mask_nxt;
  logic             timeout_nxt;
  logic [3:0]       eff;
  logic [1:0]       win;

  assign eff  = req & ~mask;
  assign busy = (state == BUSY);

`ifdef ROUND_ROBIN_EN
  logic [1:0] rr_ptr, rr_ptr_nxt;

  // Search k+1, k+2, k+3, k: walk backwards so the nearest hit is assigned last.
  function automatic logic [1:0] pick_rr(input logic [3:0] r, input logic [1:0] k);
    logic [1:0] idx;
    pick_rr = k;
    for (int i = 4; i >= 1; i--) begin
      idx = k + 2'(i);
      if (r[idx]) pick_rr = idx;
    end
  endfunction

  assign win = pick_rr(eff, rr_ptr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= 2'd0;
    else        rr_ptr <= rr_ptr_nxt;
  end
`else
  function automatic logic [1:0] pick_fixed(input logic [3:0] r);
    if (r[3])      pick_fixed = 2'd3;
    else if (r[2]) pick_fixed = 2'd2;
    else if (r[1]) pick_fixed = 2'd1;
    else           pick_fixed = 2'd0;
  endfunction

  assign win = pick_fixed(eff);
`endif

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    gnt_id_nxt   = gnt_id;
    hold_cnt_nxt = hold_cnt;
    timeout_nxt  = 1'b0;
    // A source that drops its request is forgiven on that same edge.
    mask_nxt     = mask & req;
`ifdef ROUND_ROBIN_EN
    rr_ptr_nxt   = rr_ptr;
`endif
    case (state)
      IDLE, GAP: begin
        if (eff != 4'b0000) begin
          state_nxt    = BUSY;
          gnt_nxt      = 4'b0001 << win;
          gnt_id_nxt   = win;
          hold_cnt_nxt = '0;
`ifdef ROUND_ROBIN_EN
          rr_ptr_nxt   = win;
`endif
        end else if (state == GAP) begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (!req[gnt_id]) begin
          state_nxt = GAP;
          gnt_nxt   = 4'b0000;
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
          state_nxt        = GAP;
          gnt_nxt          = 4'b0000;
          timeout_nxt      = 1'b1;
          mask_nxt[gnt_id] = 1'b1;
        end else if (hold_cnt != '1) begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      gnt_id   <= 2'd0;
      hold_cnt <= '0;
      mask     <= 4'b0000;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      hold_cnt <= hold_cnt_nxt;
      mask     <= mask_nxt;
      timeout  <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_priority_arbiter.sv
// Scoreboard bench for priority_arbiter (MAX_HOLD=4): stimulus queues expected outputs, a monitor compares them.
module tb_priority_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       t;
  } exp_t;

  exp_t q[$];

  priority_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Drive one request vector and queue the outputs expected after the next rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] eid,
                      input logic eb, input logic et);
    exp_t e;
    @(negedge clk);
    req  = r;
    e.g  = eg;
    e.id = eid;
    e.b  = eb;
    e.t  = et;
    q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: compare after every rising edge for which an expectation is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("gnt", int'(gnt), int'(e.g));
        check("busy", int'(busy), int'(e.b));
        check("timeout", int'(timeout), int'(e.t));
        if (e.b) check("gnt_id", int'(gnt_id), int'(e.id));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    req   = 4'b0000;
    #1 rst_n = 1'b0;
    #12;
    check("rst_gnt", int'(gnt), 0);
    check("rst_gnt_id", int'(gnt_id), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_timeout", int'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Two requesters: 2 wins, then 0 after a one-cycle gap.
    step(4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef ROUND_ROBIN_EN
    // All four requesting, re-raised right after each drop: order 1, 2, 3, 0, 1.
    step(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b1101, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b1011, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`else
    // All four requesting, each owner drops after 3 granted cycles: order 3, 2, 1, 0.
    step(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b0111, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0111, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0111, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0111, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0011, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

    // Hold timeout: 4 granted cycles, one pulse, then locked out until req[1] drops.
    step(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b0010, 4'b0000, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Release on the same edge the hold limit is reached: no pulse, no lockout.
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Higher-priority request mid-grant does not preempt source 0.
    step(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a grant, then re-arbitration.
    step(4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_gnt", int'(gnt), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_timeout", int'(timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b0101, 4'b0100, 2'd2, 1'b1, 1'b0);
    step(4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

    #3;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Sequential 4-requester arbiter that shares one downstream resource using the team's 4:1 priority-encoding scheme, where req[3] has the highest priority. It sits between up to four request sources and the shared datapath. It issues a registered one-hot grant plus its 2-bit encoded index, holds the grant while the winner keeps requesting, and enforces a bounded hold time. A one-cycle turnaround gap is inserted between grants.

## Interface
- MAX_HOLD, 16, maximum consecutive BUSY cycles per grant; 0 disables the timeout
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  level request per source; held high until service is done
- gnt  output  4  registered one-hot grant; 0 when no owner
- gnt_id  output  2  encoded index of the owner; valid only when busy=1
- busy  output  1  high while a grant is active (state BUSY)
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked

## Operation
- States: IDLE, BUSY, GAP. Reset state is IDLE.
- Reset values: gnt=0, gnt_id=0, busy=0, timeout=0, hold counter=0, mask=0, rr pointer=0.
- Eligible requests are eff = req & ~mask.
- IDLE or GAP with eff!=0:
  - The winner is picked by the priority rule (see Configuration).
  - State goes to BUSY. gnt gets the one-hot of the winner and gnt_id its index.
  - The hold counter is cleared.
- IDLE with eff=0: stay in IDLE.
- GAP with eff=0: go to IDLE.
- BUSY, normal release: if req[gnt_id]=0 at the edge, gnt goes to 0 and the state goes to GAP.
- BUSY, forced release: if MAX_HOLD!=0, req[gnt_id]=1 and the hold counter equals MAX_HOLD-1 at the edge:
  - gnt goes to 0, state goes to GAP, timeout=1 for one cycle.
  - mask[gnt_id] is set.
- BUSY otherwise: the hold counter increments and the grant is unchanged.
- Mask rules:
  - mask[i] clears on any edge where req[i]=0.
  - A timed-out source cannot win again until it deasserts req for at least one cycle.
- Grant changes never happen inside BUSY. A higher-priority request arriving mid-grant does not preempt.
- Hold counter width is $clog2(MAX_HOLD+1), minimum 1. It saturates and never wraps when MAX_HOLD=0.

## Timing
- Grant latency: a req seen at edge N in IDLE gives gnt high after edge N, i.e. one cycle.
- Release latency: req[owner] low at edge M gives gnt low after edge M.
- Back-to-back grants:
  - gnt is 0 for exactly one cycle (GAP) between two owners.
  - The next grant is driven after edge M+1.
- Timeout:
  - The owner sees gnt high for exactly MAX_HOLD cycles.
  - timeout is asserted in the cycle after the last granted cycle, coincident with the first GAP cycle.
- Simultaneous events:
  - Release and timeout on the same edge: treated as a normal release. No pulse, no mask.
  - A masked source's req falling on the same edge another grant is made: the mask clears, but that source is not considered until the next edge.
- Reset mid-grant:
  - Asserting rst_n low immediately (asynchronously) forces gnt=0 and busy=0, and the state returns to IDLE.
  - After rst_n is released, the first possible grant is driven after the first rising edge.
- Outputs depend only on registers; there are no combinational paths from req.

## Configuration
- ROUND_ROBIN_EN defined:
  - Rotating priority. The pointer holds the last granted index k and updates on each grant.
  - Search order is k+1, k+2, k+3, k (mod 4).
  - The pointer resets to 0, so the first search order is 1, 2, 3, 0.
- ROUND_ROBIN_EN undefined:
  - Fixed priority 3 > 2 > 1 > 0, the same as the team's priority encoder.
  - The pointer logic is not built.

## Test plan
- Reset then req=4'b0101 held: gnt=4'b0100 and gnt_id=2 after one edge, busy=1. With ROUND_ROBIN_EN, gnt=4'b0001 after req[2] drops, with a 1-cycle GAP. Fixed priority gives the same result here.
- Fixed priority, req=4'b1111 held, each owner drops req after 3 cycles: grant sequence is 3, 2, 1, 0, each 3 cycles long, separated by a 1-cycle gnt=0.
- ROUND_ROBIN_EN, req=4'b1111 held and re-raised immediately after each drop: grant order is 1, 2, 3, 0, 1.
- MAX_HOLD=4, req=4'b0010 held for 20 cycles:
  - gnt=4'b0010 for exactly 4 cycles, then timeout pulses once.
  - gnt stays 0 until req[1] drops for 1 cycle and rises again.
- req[3] rises while source 0 owns the grant: gnt stays 4'b0001 until req[0] drops, then source 3 is granted after the GAP.
- rst_n pulsed low mid-BUSY (between clock edges): gnt=0, busy=0 immediately. Re-arbitration after release follows the first scenario.
